// File: rtl/byte_striping_tx_multilane.sv
// byte_striping_tx_multilane: stripes a serial symbol stream round-robin across LANES output lanes
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   valid, data  : input symbol stream, no backpressure
//   active_lanes : requested lane count, sampled only at stripe start (0 or >LANES means LANES)
//   data_out     : registered packed lane data, lane i at [i*WIDTH +: WIDTH]
//   valid_out    : registered per-lane valid, one-cycle pulse per launched stripe
//   stripe_count : registered count of launched stripes (full or flushed), wraps silently
module byte_striping_tx_multilane #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter logic [WIDTH-1:0] PAD = '0,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid,
    input  logic [WIDTH-1:0]          data,
    input  logic [$clog2(LANES):0]    active_lanes,
    output logic [LANES*WIDTH-1:0]    data_out,
    output logic [LANES-1:0]          valid_out,
    output logic [CNT_W-1:0]          stripe_count
);
    localparam int AW = $clog2(LANES) + 1;
    localparam int PW = LANES > 1 ? $clog2(LANES) : 1;
    logic [PW-1:0]          r_ptr;
    logic [AW-1:0]          r_n;
    logic [WIDTH-1:0]       r_hold [LANES];
    logic [LANES*WIDTH-1:0] r_dout;
    logic [LANES-1:0]       r_vout;
    logic [CNT_W-1:0]       r_cnt;
    logic [AW-1:0]          w_nsel;
    logic [AW-1:0]          w_ncur;
    logic [AW-1:0]          w_fill;
    logic                   w_launch;
    logic [LANES*WIDTH-1:0] w_dout;
    logic [LANES-1:0]       w_vout;
    always_comb begin
        w_nsel   = (active_lanes == '0 || active_lanes > AW'(LANES)) ? AW'(LANES) : active_lanes;
        // the lane count sampled on a stripe's first edge already governs that edge
        w_ncur   = (r_ptr == '0) ? w_nsel : r_n;
        // lanes carried by a launch: the whole stripe on completion, the filled part on flush
        w_fill   = valid ? w_ncur : AW'(r_ptr);
        w_launch = valid ? (AW'(r_ptr) == w_ncur - 1'b1) : (r_ptr != '0);
        w_dout   = '0;
        w_vout   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_vout[i]               = AW'(i) < w_fill;
            w_dout[i*WIDTH +: WIDTH] = !w_vout[i] ? PAD :
                                       (valid && AW'(r_ptr) == AW'(i)) ? data : r_hold[i];
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr  <= '0;
            r_n    <= AW'(LANES);
            r_dout <= '0;
            r_vout <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < LANES; i++) r_hold[i] <= '0;
        end else begin
            if (r_ptr == '0) r_n <= w_nsel;
            r_vout <= w_launch ? w_vout : '0;
            if (w_launch) begin
                r_dout <= w_dout;
                r_cnt  <= r_cnt + 1'b1;
                r_ptr  <= '0;
            end else if (valid) begin
                r_hold[r_ptr] <= data;
                r_ptr         <= r_ptr + 1'b1;
            end
        end
    end
    assign data_out     = r_dout;
    assign valid_out    = r_vout;
    assign stripe_count = r_cnt;
endmodule

// File: tb/tb_byte_striping_tx_multilane.sv
// tb_byte_striping_tx_multilane: table-driven and scoreboarded checks of the lane striper
module tb_byte_striping_tx_multilane;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  data = '0;
    logic [2:0]  active_lanes = 3'd4;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic [3:0]  stripe_count;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [2:0]  al;
        logic [3:0]  ev;
        logic [31:0] ed;
        logic [3:0]  ec;
        logic        cd;
    } vec_t;

    vec_t tbl [27];
    vec_t q [$];

    byte_striping_tx_multilane #(.WIDTH(8), .LANES(4), .PAD(8'hEE), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .valid(valid), .data(data), .active_lanes(active_lanes),
        .data_out(data_out), .valid_out(valid_out), .stripe_count(stripe_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string nm);
        vec_t e;
        valid = t.v;
        data = t.d;
        active_lanes = t.al;
        q.push_back(t);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty got 0 want 1", nm);
        end else begin
            e = q.pop_front();
            chk({nm, "_vout"}, 32'(valid_out), 32'(e.ev));
            chk({nm, "_cnt"}, 32'(stripe_count), 32'(e.ec));
            if (e.cd) chk({nm, "_dout"}, data_out, e.ed);
        end
    endtask

    initial begin
        vec_t w;
        // full stripes, 4 lanes
        tbl[0]  = '{1'b1, 8'h00, 3'd4, 4'h0, 32'h0, 4'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'h01, 3'd4, 4'h0, 32'h0, 4'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'h02, 3'd4, 4'h0, 32'h0, 4'd0, 1'b0};
        tbl[3]  = '{1'b1, 8'h03, 3'd4, 4'hF, 32'h03020100, 4'd1, 1'b1};
        tbl[4]  = '{1'b1, 8'h04, 3'd4, 4'h0, 32'h0, 4'd1, 1'b0};
        tbl[5]  = '{1'b1, 8'h05, 3'd4, 4'h0, 32'h0, 4'd1, 1'b0};
        tbl[6]  = '{1'b1, 8'h06, 3'd4, 4'h0, 32'h0, 4'd1, 1'b0};
        tbl[7]  = '{1'b1, 8'h07, 3'd4, 4'hF, 32'h07060504, 4'd2, 1'b1};
        // reduced lanes
        tbl[8]  = '{1'b1, 8'hA0, 3'd2, 4'h0, 32'h0, 4'd2, 1'b0};
        tbl[9]  = '{1'b1, 8'hA1, 3'd2, 4'h3, 32'hEEEEA1A0, 4'd3, 1'b1};
        tbl[10] = '{1'b1, 8'hA2, 3'd2, 4'h0, 32'h0, 4'd3, 1'b0};
        tbl[11] = '{1'b1, 8'hA3, 3'd2, 4'h3, 32'hEEEEA3A2, 4'd4, 1'b1};
        // partial flush, then idle holds data
        tbl[12] = '{1'b1, 8'h11, 3'd4, 4'h0, 32'h0, 4'd4, 1'b0};
        tbl[13] = '{1'b1, 8'h22, 3'd4, 4'h0, 32'h0, 4'd4, 1'b0};
        tbl[14] = '{1'b1, 8'h33, 3'd4, 4'h0, 32'h0, 4'd4, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 3'd4, 4'h7, 32'hEE332211, 4'd5, 1'b1};
        tbl[16] = '{1'b0, 8'h99, 3'd4, 4'h0, 32'hEE332211, 4'd5, 1'b1};
        // lane count change mid-stripe is deferred
        tbl[17] = '{1'b1, 8'h40, 3'd4, 4'h0, 32'h0, 4'd5, 1'b0};
        tbl[18] = '{1'b1, 8'h41, 3'd4, 4'h0, 32'h0, 4'd5, 1'b0};
        tbl[19] = '{1'b1, 8'h42, 3'd1, 4'h0, 32'h0, 4'd5, 1'b0};
        tbl[20] = '{1'b1, 8'h43, 3'd1, 4'hF, 32'h43424140, 4'd6, 1'b1};
        tbl[21] = '{1'b1, 8'h50, 3'd1, 4'h1, 32'hEEEEEE50, 4'd7, 1'b1};
        // zero lane request maps to all lanes
        tbl[22] = '{1'b1, 8'h70, 3'd0, 4'h0, 32'h0, 4'd7, 1'b0};
        tbl[23] = '{1'b1, 8'h71, 3'd0, 4'h0, 32'h0, 4'd7, 1'b0};
        tbl[24] = '{1'b1, 8'h72, 3'd0, 4'h0, 32'h0, 4'd7, 1'b0};
        tbl[25] = '{1'b1, 8'h73, 3'd0, 4'hF, 32'h73727170, 4'd8, 1'b1};
        // first symbol of a stripe that reset will discard
        tbl[26] = '{1'b1, 8'h60, 3'd4, 4'h0, 32'h0, 4'd8, 1'b0};

        #2 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_vout", 32'(valid_out), 32'h0);
            chk("rst_dout", data_out, 32'h0);
            chk("rst_cnt", 32'(stripe_count), 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) apply('{1'b0, 8'h00, 3'd4, 4'h0, 32'h0, 4'd0, 1'b1}, "idle");

        for (int i = 0; i < 27; i++) apply(tbl[i], $sformatf("vec%0d", i));

        #2 reset = 1'b0;
        #1;
        chk("async_rst_dout", data_out, 32'h0);
        chk("async_rst_cnt", 32'(stripe_count), 32'h0);
        chk("async_rst_vout", 32'(valid_out), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) apply('{1'b0, 8'h00, 3'd4, 4'h0, 32'h0, 4'd0, 1'b1}, "post_rst");

        for (int k = 1; k <= 17; k++) begin
            w = '{1'b1, 8'(k), 3'd1, 4'h1, {24'hEEEEEE, 8'(k)}, 4'(k), 1'b1};
            apply(w, $sformatf("wrap%0d", k));
        end
        apply('{1'b0, 8'h00, 3'd1, 4'h0, 32'hEEEEEE11, 4'd1, 1'b1}, "wrap_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
